// File: rtl/trajectory_pkg.sv
// Shared types and default constants for the ballistic trajectory stepper.
package trajectory_pkg;

    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_MAX_STEPS = 256;
    localparam int unsigned DEF_G         = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of a sample index able to count 0 .. n-1.
    function automatic int unsigned step_bits(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trajectory_stepper_if.sv
// Sample output stream of the trajectory stepper (valid/ready handshake).
interface trajectory_stepper_if
    import trajectory_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_STEPS = DEF_MAX_STEPS
);
    localparam int unsigned STEP_W = step_bits(MAX_STEPS);

    logic                     out_valid;
    logic                     out_ready;
    logic signed [WIDTH-1:0]  out_x;
    logic signed [WIDTH-1:0]  out_y;
    logic [STEP_W-1:0]        out_step;
    logic                     out_last;

    modport master (
        output out_valid,
        output out_x,
        output out_y,
        output out_step,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_x,
        input  out_y,
        input  out_step,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/traj_step_alu.sv
// Next-state sums for one trajectory step, with signed overflow flag per sum.
module traj_step_alu
    import trajectory_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned G     = DEF_G
) (
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] y_i,
    input  logic signed [WIDTH-1:0] vx_i,
    input  logic signed [WIDTH-1:0] vy_i,
    output logic signed [WIDTH-1:0] x_nx_c,
    output logic signed [WIDTH-1:0] y_nx_c,
    output logic signed [WIDTH-1:0] vy_nx_c,
    output logic                    ovf_x_c,
    output logic                    ovf_y_c,
    output logic                    ovf_vy_c
);
    localparam logic signed [WIDTH-1:0] G_W = $signed(WIDTH'(G));

    assign x_nx_c  = x_i + vx_i;
    assign y_nx_c  = y_i + vy_i;
    assign vy_nx_c = vy_i - G_W;

    // Addition overflows when both operands agree in sign and the result does not.
    assign ovf_x_c = (x_i[WIDTH-1] == vx_i[WIDTH-1]) && (x_nx_c[WIDTH-1] != x_i[WIDTH-1]);
    assign ovf_y_c = (y_i[WIDTH-1] == vy_i[WIDTH-1]) && (y_nx_c[WIDTH-1] != y_i[WIDTH-1]);
    // Subtraction is addition of -G: overflow needs differing operand signs.
    assign ovf_vy_c = (vy_i[WIDTH-1] != G_W[WIDTH-1]) && (vy_nx_c[WIDTH-1] != vy_i[WIDTH-1]);

endmodule

// File: rtl/trajectory_stepper.sv
// Streams projectile positions under constant gravity until landing, step limit or overflow.
module trajectory_stepper
    import trajectory_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_STEPS = DEF_MAX_STEPS,
    parameter int unsigned G         = DEF_G
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] vx0,
    input  logic signed [WIDTH-1:0] vy0,
    output logic                    busy,
    output logic                    done,
    output logic                    landed,
    output logic                    timeout,
    output logic                    ovf,
    trajectory_stepper_if.master    out
);
    localparam int unsigned STEP_W = step_bits(MAX_STEPS);

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic signed [WIDTH-1:0] vx_q, vx_d, vy_q, vy_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic                    landed_q, landed_d;
    logic                    timeout_q, timeout_d;
    logic                    ovf_q, ovf_d;

    logic signed [WIDTH-1:0] x_nx, y_nx, vy_nx;
    logic                    ovf_x, ovf_y, ovf_vy;
    logic                    emit, hs;
    logic                    cause_land, cause_tmo, cause_ovf, last_c;

    traj_step_alu #(
        .WIDTH (WIDTH),
        .G     (G)
    ) u_alu (
        .x_i      (x_q),
        .y_i      (y_q),
        .vx_i     (vx_q),
        .vy_i     (vy_q),
        .x_nx_c   (x_nx),
        .y_nx_c   (y_nx),
        .vy_nx_c  (vy_nx),
        .ovf_x_c  (ovf_x),
        .ovf_y_c  (ovf_y),
        .ovf_vy_c (ovf_vy)
    );

    // Termination causes evaluated on the sample currently presented.
    assign emit       = (state_q == ST_EMIT);
    assign hs         = emit && out.out_ready;
    assign cause_land = y_q[WIDTH-1];
    assign cause_tmo  = (step_q == STEP_W'(MAX_STEPS - 1));
    assign cause_ovf  = ovf_x || ovf_y || ovf_vy;
    assign last_c     = emit && (cause_land || cause_tmo || cause_ovf);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        step_d    = step_q;
        landed_d  = landed_q;
        timeout_d = timeout_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d       = x0;
                    y_d       = y0;
                    vx_d      = vx0;
                    vy_d      = vy0;
                    step_d    = '0;
                    landed_d  = 1'b0;
                    timeout_d = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (hs) begin
                    // The final sample is never advanced, so no wrapped value escapes.
                    if (last_c) begin
                        landed_d  = cause_land;
                        timeout_d = cause_tmo;
                        ovf_d     = cause_ovf;
                        state_d   = ST_DONE;
                    end else begin
                        x_d    = x_nx;
                        y_d    = y_nx;
                        vy_d   = vy_nx;
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            step_q    <= '0;
            landed_q  <= 1'b0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            step_q    <= step_d;
            landed_q  <= landed_d;
            timeout_q <= timeout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign landed  = landed_q;
    assign timeout = timeout_q;
    assign ovf     = ovf_q;

    assign out.out_valid = emit;
    assign out.out_x     = x_q;
    assign out.out_y     = y_q;
    assign out.out_step  = step_q;
    assign out.out_last  = last_c;

endmodule

// File: tb/tb_trajectory_stepper.sv
// Directed bench: default, short-timeout and 8-bit-overflow instances of trajectory_stepper.
module tb_trajectory_stepper;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start0, start1, start2;
    logic signed [15:0] x0_a, y0_a, vx0_a, vy0_a;
    logic signed [15:0] x0_b, y0_b, vx0_b, vy0_b;
    logic signed [7:0]  x0_c, y0_c, vx0_c, vy0_c;
    logic busy0, done0, landed0, timeout0, ovf0;
    logic busy1, done1, landed1, timeout1, ovf1;
    logic busy2, done2, landed2, timeout2, ovf2;

    int n_assert = 0;
    int n_fail   = 0;
    int ey[11] = '{10, 13, 15, 16, 16, 15, 13, 10, 6, 1, -5};

    trajectory_stepper_if #(.WIDTH(16), .MAX_STEPS(256)) bus0 ();
    trajectory_stepper_if #(.WIDTH(16), .MAX_STEPS(4))   bus1 ();
    trajectory_stepper_if #(.WIDTH(8),  .MAX_STEPS(256)) bus2 ();

    trajectory_stepper #(.WIDTH(16), .MAX_STEPS(256), .G(1)) u0 (
        .clk(clk), .rst(rst), .start(start0),
        .x0(x0_a), .y0(y0_a), .vx0(vx0_a), .vy0(vy0_a),
        .busy(busy0), .done(done0), .landed(landed0), .timeout(timeout0), .ovf(ovf0),
        .out(bus0)
    );
    trajectory_stepper #(.WIDTH(16), .MAX_STEPS(4), .G(1)) u1 (
        .clk(clk), .rst(rst), .start(start1),
        .x0(x0_b), .y0(y0_b), .vx0(vx0_b), .vy0(vy0_b),
        .busy(busy1), .done(done1), .landed(landed1), .timeout(timeout1), .ovf(ovf1),
        .out(bus1)
    );
    trajectory_stepper #(.WIDTH(8), .MAX_STEPS(256), .G(1)) u2 (
        .clk(clk), .rst(rst), .start(start2),
        .x0(x0_c), .y0(y0_c), .vx0(vx0_c), .vy0(vy0_c),
        .busy(busy2), .done(done2), .landed(landed2), .timeout(timeout2), .ovf(ovf2),
        .out(bus2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sample0(input string tag, input int k, input int y);
        chk({tag, " valid"}, int'(bus0.out_valid), 1);
        chk({tag, " x"}, int'($signed(bus0.out_x)), 2 * k);
        chk({tag, " y"}, int'($signed(bus0.out_y)), y);
        chk({tag, " step"}, int'(bus0.out_step), k);
        chk({tag, " last"}, int'(bus0.out_last), (k == 10) ? 1 : 0);
    endtask

    // Full default-instance run: optional stall at one step, optional ignored start pulse.
    task automatic run0(input int stall_at, input int stall_len, input int start_at);
        x0_a = 16'sd0; y0_a = 16'sd10; vx0_a = 16'sd2; vy0_a = 16'sd3;
        bus0.out_ready = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("run0 flags cleared", int'({landed0, timeout0, ovf0}), 0);
        for (int k = 0; k <= 10; k++) begin
            chk_sample0($sformatf("run0 s%0d", k), k, ey[k]);
            if (k == stall_at) begin
                bus0.out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    chk_sample0($sformatf("run0 stall%0d", s), k, ey[k]);
                end
                bus0.out_ready = 1'b1;
            end
            if (k == start_at) begin
                x0_a = 16'sd100; y0_a = -16'sd50;
                start0 = 1'b1;
            end
            tick();
            start0 = 1'b0;
            x0_a = 16'sd0; y0_a = 16'sd10;
        end
        chk("run0 done", int'(done0), 1);
        chk("run0 done busy", int'(busy0), 1);
        chk("run0 done valid", int'(bus0.out_valid), 0);
        chk("run0 causes", int'({landed0, timeout0, ovf0}), 3'b100);
        tick();
        chk("run0 idle done", int'(done0), 0);
        chk("run0 idle busy", int'(busy0), 0);
        chk("run0 landed held", int'(landed0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        x0_a = '0; y0_a = '0; vx0_a = '0; vy0_a = '0;
        x0_b = '0; y0_b = '0; vx0_b = '0; vy0_b = '0;
        x0_c = '0; y0_c = '0; vx0_c = '0; vy0_c = '0;
        bus0.out_ready = 1'b1; bus1.out_ready = 1'b1; bus2.out_ready = 1'b1;
        tick();
        tick();
        chk("reset busy", int'(busy0), 0);
        chk("reset valid", int'(bus0.out_valid), 0);
        chk("reset done", int'(done0), 0);
        chk("reset last", int'(bus0.out_last), 0);
        rst = 1'b0;
        tick();
        chk("post-reset idle valid", int'(bus0.out_valid), 0);

        // Nominal flight, then stalled flight, then flight with an ignored start.
        run0(-1, 0, -1);
        run0(2, 3, -1);
        run0(-1, 0, 3);

        // Step-limit termination with MAX_STEPS=4.
        x0_b = 16'sd0; y0_b = 16'sd0; vx0_b = 16'sd0; vy0_b = 16'sd100;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("tmo s0 y", int'($signed(bus1.out_y)), 0);
        chk("tmo s0 last", int'(bus1.out_last), 0);
        tick();
        chk("tmo s1 y", int'($signed(bus1.out_y)), 100);
        tick();
        chk("tmo s2 y", int'($signed(bus1.out_y)), 199);
        chk("tmo s2 last", int'(bus1.out_last), 0);
        tick();
        chk("tmo s3 y", int'($signed(bus1.out_y)), 297);
        chk("tmo s3 step", int'(bus1.out_step), 3);
        chk("tmo s3 last", int'(bus1.out_last), 1);
        tick();
        chk("tmo done", int'(done1), 1);
        chk("tmo causes", int'({landed1, timeout1, ovf1}), 3'b010);
        tick();
        chk("tmo idle busy", int'(busy1), 0);

        // Overflow on the very first sample with WIDTH=8.
        x0_c = 8'sd0; y0_c = 8'sd120; vx0_c = 8'sd0; vy0_c = 8'sd10;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("ovf s0 valid", int'(bus2.out_valid), 1);
        chk("ovf s0 y", int'($signed(bus2.out_y)), 120);
        chk("ovf s0 last", int'(bus2.out_last), 1);
        tick();
        chk("ovf done", int'(done2), 1);
        chk("ovf causes", int'({landed2, timeout2, ovf2}), 3'b001);
        chk("ovf y not wrapped", int'($signed(bus2.out_y)), 120);
        tick();
        chk("ovf idle busy", int'(busy2), 0);

        // Asynchronous reset in the middle of a flight.
        x0_a = 16'sd0; y0_a = 16'sd10; vx0_a = 16'sd2; vy0_a = 16'sd3;
        bus0.out_ready = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("pre-rst step", int'(bus0.out_step), 5);
        chk("pre-rst y", int'($signed(bus0.out_y)), 15);
        #2;
        rst = 1'b1;
        #1;
        chk("rst busy", int'(busy0), 0);
        chk("rst valid", int'(bus0.out_valid), 0);
        chk("rst last", int'(bus0.out_last), 0);
        chk("rst done", int'(done0), 0);
        chk("rst causes", int'({landed0, timeout0, ovf0}), 0);
        chk("rst x", int'($signed(bus0.out_x)), 0);
        chk("rst y", int'($signed(bus0.out_y)), 0);
        chk("rst step", int'(bus0.out_step), 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("post-rst valid", int'(bus0.out_valid), 0);
        chk("post-rst busy", int'(busy0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
